ch_pack: RTL and testbench



---
 rtl/ch_pack.sv | 166 ++++++++++++++++
 tb/tb_ch_pack.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ch_pack.sv
// Channel buffer between the DMA engine and the compression core: packs 32-bit DMA words into
// 64-bit core words on the source path and unpacks 64-bit core words on the destination path.
module ch_pack #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned SRC_THRESH = 256,
  parameter int unsigned DST_THRESH = 128,
  parameter bit          SWAP       = 1'b1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  m_reset,
  input  logic                  src_xfer,
  input  logic [31:0]           src_dat_o,
  input  logic                  src_last,
  output logic                  src_start,
  output logic                  src_stop,
  input  logic                  m_src_getn,
  output logic [63:0]           m_src,
  output logic                  m_src_last,
  output logic                  m_src_empty,
  output logic                  m_src_almost_empty,
  input  logic                  m_dst_putn,
  input  logic [63:0]           m_dst,
  input  logic                  m_dst_last,
  output logic                  m_dst_full,
  output logic                  m_dst_almost_full,
  input  logic                  m_endn,
  input  logic                  dst_xfer,
  output logic [31:0]           dst_dat_i,
  output logic                  dst_valid,
  output logic                  dst_end,
  output logic                  dst_start,
  output logic                  dst_stop,
  output logic [DEPTH_LOG2:0]   src_level,
  output logic [DEPTH_LOG2:0]   dst_level,
  output logic                  src_ovf,
  output logic                  dst_ovf,
  output logic [15:0]           ocnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return SWAP ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  // Entries are {upper word, lower word, last}.
  logic [64:0]           src_mem [DEPTH];
  logic [64:0]           dst_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] src_wr_q, src_rd_q, dst_wr_q, dst_rd_q;
  logic [LW-1:0]         src_level_q, dst_level_q;
  logic                  half_q, sel_q, src_ovf_q, dst_ovf_q;
  logic [31:0]           lower_q;
  logic [15:0]           ocnt_q;

  logic [31:0] src_word;
  logic [64:0] src_entry, dst_entry, src_head, dst_head;
  logic        src_push, src_full, src_push_ok, src_pop_ok;
  logic        dst_push, dst_full, dst_push_ok, dst_pop_ok, dst_adv;

  always_comb begin
    src_word    = bswap(src_dat_o);
    src_push    = src_xfer & (half_q | src_last);
    src_full    = (src_level_q == LW'(DEPTH));
    src_push_ok = src_push & ~src_full;
    src_pop_ok  = ~m_src_getn & (src_level_q != '0);
    src_entry   = half_q ? {src_word, lower_q, src_last} : {32'h0, src_word, 1'b1};

    dst_push    = ~m_dst_putn;
    dst_full    = (dst_level_q == LW'(DEPTH));
    dst_push_ok = dst_push & ~dst_full;
    dst_adv     = dst_xfer & (dst_level_q != '0);
    dst_pop_ok  = dst_adv & sel_q;
    dst_entry   = {bswap(m_dst[63:32]), bswap(m_dst[31:0]), m_dst_last};
  end

  always_ff @(posedge wb_clk_i) begin
    if (src_push_ok) src_mem[src_wr_q] <= src_entry;
    if (dst_push_ok) dst_mem[dst_wr_q] <= dst_entry;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      src_wr_q    <= '0;
      src_rd_q    <= '0;
      src_level_q <= '0;
      half_q      <= 1'b0;
      lower_q     <= '0;
      src_ovf_q   <= 1'b0;
    end else if (m_reset) begin
      src_wr_q    <= '0;
      src_rd_q    <= '0;
      src_level_q <= '0;
      half_q      <= 1'b0;
      lower_q     <= '0;
      src_ovf_q   <= 1'b0;
    end else begin
      if (src_xfer) begin
        if (half_q) begin
          half_q <= 1'b0;
        end else if (!src_last) begin
          lower_q <= src_word;
          half_q  <= 1'b1;
        end
      end
      if (src_push_ok) src_wr_q <= src_wr_q + DEPTH_LOG2'(1);
      if (src_pop_ok)  src_rd_q <= src_rd_q + DEPTH_LOG2'(1);
      src_level_q <= src_level_q + LW'(src_push_ok) - LW'(src_pop_ok);
      if (src_push && src_full) src_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dst_wr_q    <= '0;
      dst_rd_q    <= '0;
      dst_level_q <= '0;
      sel_q       <= 1'b0;
      dst_ovf_q   <= 1'b0;
      ocnt_q      <= '0;
    end else if (m_reset) begin
      dst_wr_q    <= '0;
      dst_rd_q    <= '0;
      dst_level_q <= '0;
      sel_q       <= 1'b0;
      dst_ovf_q   <= 1'b0;
      ocnt_q      <= '0;
    end else begin
      if (dst_adv) sel_q <= ~sel_q;
      if (dst_push_ok) dst_wr_q <= dst_wr_q + DEPTH_LOG2'(1);
      if (dst_pop_ok)  dst_rd_q <= dst_rd_q + DEPTH_LOG2'(1);
      dst_level_q <= dst_level_q + LW'(dst_push_ok) - LW'(dst_pop_ok);
      if (dst_push && dst_full) dst_ovf_q <= 1'b1;
      // Counted even when the push itself is dropped.
      if (dst_push && !m_dst_last && ocnt_q != 16'hFFFF) ocnt_q <= ocnt_q + 16'd1;
    end
  end

  // The head of each FIFO is read through directly (first-word fall-through).
  always_comb begin
    src_head           = src_mem[src_rd_q];
    dst_head           = dst_mem[dst_rd_q];
    m_src_empty        = (src_level_q == '0);
    m_src_almost_empty = (src_level_q <= LW'(1));
    m_src              = m_src_empty ? 64'h0 : src_head[64:1];
    m_src_last         = ~m_src_empty & src_head[0];
    src_start          = (src_level_q <= LW'(DEPTH - 2));
    src_stop           = (src_level_q >= LW'(SRC_THRESH));

    dst_valid          = (dst_level_q != '0);
    dst_dat_i          = !dst_valid ? 32'h0 : (sel_q ? dst_head[64:33] : dst_head[32:1]);
    dst_end            = dst_valid & sel_q & dst_head[0];
    dst_stop           = ~dst_valid;
    dst_start          = (dst_level_q >= LW'(DST_THRESH)) | (~m_endn & dst_valid);
    m_dst_full         = dst_full;
    m_dst_almost_full  = (dst_level_q >= LW'(DEPTH - 1));

    src_level          = src_level_q;
    dst_level          = dst_level_q;
    src_ovf            = src_ovf_q;
    dst_ovf            = dst_ovf_q;
    ocnt               = ocnt_q;
  end

endmodule

// File: tb/tb_ch_pack.sv
// Self-checking bench for ch_pack: directed test-plan cases plus randomized traffic compared
// every cycle against a queue-based model.
module tb_ch_pack;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int ST    = 8;
  localparam int DT    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_reset, src_xfer, src_last, m_src_getn, m_dst_putn, m_dst_last, m_endn, dst_xfer;
  logic [31:0] src_dat_o;
  logic [63:0] m_dst;
  logic        src_start, src_stop, m_src_last, m_src_empty, m_src_almost_empty;
  logic        m_dst_full, m_dst_almost_full, dst_valid, dst_end, dst_start, dst_stop;
  logic        src_ovf, dst_ovf;
  logic [63:0] m_src;
  logic [31:0] dst_dat_i;
  logic [DL:0] src_level, dst_level;
  logic [15:0] ocnt;

  always #5 clk = ~clk;

  ch_pack #(.DEPTH_LOG2(DL), .SRC_THRESH(ST), .DST_THRESH(DT), .SWAP(1'b1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .m_reset(m_reset),
    .src_xfer(src_xfer), .src_dat_o(src_dat_o), .src_last(src_last),
    .src_start(src_start), .src_stop(src_stop), .m_src_getn(m_src_getn),
    .m_src(m_src), .m_src_last(m_src_last), .m_src_empty(m_src_empty),
    .m_src_almost_empty(m_src_almost_empty), .m_dst_putn(m_dst_putn), .m_dst(m_dst),
    .m_dst_last(m_dst_last), .m_dst_full(m_dst_full), .m_dst_almost_full(m_dst_almost_full),
    .m_endn(m_endn), .dst_xfer(dst_xfer), .dst_dat_i(dst_dat_i), .dst_valid(dst_valid),
    .dst_end(dst_end), .dst_start(dst_start), .dst_stop(dst_stop),
    .src_level(src_level), .dst_level(dst_level), .src_ovf(src_ovf), .dst_ovf(dst_ovf),
    .ocnt(ocnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: queues hold {upper, lower, last}; sel counts words of the head consumed.
  logic [64:0] sq[$];
  logic [64:0] dq[$];
  bit          mh_half, mh_sel, mh_sovf, mh_dovf;
  logic [31:0] mh_lower;
  int          mh_ocnt;

  function automatic logic [31:0] bs(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [31:0] w;
    logic [64:0] entry;
    bit          spush, sfull, dfull, dpop;
    if (rst || m_reset) begin
      sq.delete(); dq.delete();
      mh_half = 0; mh_sel = 0; mh_sovf = 0; mh_dovf = 0; mh_ocnt = 0; mh_lower = '0;
    end else begin
      w     = bs(src_dat_o);
      spush = src_xfer && (mh_half || src_last);
      entry = mh_half ? {w, mh_lower, src_last} : {32'h0, w, 1'b1};
      if (src_xfer) begin
        if (mh_half) mh_half = 0;
        else if (!src_last) begin mh_lower = w; mh_half = 1; end
      end
      sfull = (sq.size() == DEPTH);
      if (!m_src_getn && sq.size() > 0) void'(sq.pop_front());
      if (spush) begin
        if (sfull) mh_sovf = 1;
        else sq.push_back(entry);
      end

      dfull = (dq.size() == DEPTH);
      dpop  = dst_xfer && dq.size() > 0 && mh_sel;
      if (dst_xfer && dq.size() > 0) mh_sel = !mh_sel;
      if (dpop) void'(dq.pop_front());
      if (!m_dst_putn) begin
        if (dfull) mh_dovf = 1;
        else dq.push_back({bs(m_dst[63:32]), bs(m_dst[31:0]), m_dst_last});
        if (!m_dst_last && mh_ocnt < 65535) mh_ocnt++;
      end
    end
  endtask

  task automatic compare_all();
    int          ss, ds;
    logic [64:0] sh, dh;
    ss = sq.size();
    ds = dq.size();
    sh = (ss > 0) ? sq[0] : 65'h0;
    dh = (ds > 0) ? dq[0] : 65'h0;
    chk("src_level", 64'(src_level), 64'(ss));
    chk("m_src", m_src, sh[64:1]);
    chk("m_src_last", 64'(m_src_last), 64'(sh[0]));
    chk("m_src_empty", 64'(m_src_empty), 64'(ss == 0));
    chk("m_src_almost_empty", 64'(m_src_almost_empty), 64'(ss <= 1));
    chk("src_start", 64'(src_start), 64'(DEPTH - ss >= 2));
    chk("src_stop", 64'(src_stop), 64'(ss >= ST));
    chk("src_ovf", 64'(src_ovf), 64'(mh_sovf));
    chk("dst_level", 64'(dst_level), 64'(ds));
    chk("dst_valid", 64'(dst_valid), 64'(ds > 0));
    chk("dst_dat_i", 64'(dst_dat_i), (ds == 0) ? 64'h0 : 64'(mh_sel ? dh[64:33] : dh[32:1]));
    chk("dst_end", 64'(dst_end), 64'(ds > 0 && mh_sel && dh[0]));
    chk("dst_stop", 64'(dst_stop), 64'(ds == 0));
    chk("dst_start", 64'(dst_start), 64'(ds >= DT || (!m_endn && ds != 0)));
    chk("m_dst_full", 64'(m_dst_full), 64'(ds == DEPTH));
    chk("m_dst_almost_full", 64'(m_dst_almost_full), 64'(ds >= DEPTH - 1));
    chk("dst_ovf", 64'(dst_ovf), 64'(mh_dovf));
    chk("ocnt", 64'(ocnt), 64'(mh_ocnt));
  endtask

  // Inputs change 1 time unit after the falling edge, so both the DUT and the model see the
  // same stable values at the rising edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (!rst) compare_all();
    #1;
  endtask

  task automatic idle();
    m_reset = 0; src_xfer = 0; src_last = 0; src_dat_o = '0; m_src_getn = 1;
    m_dst_putn = 1; m_dst = '0; m_dst_last = 0; m_endn = 1; dst_xfer = 0;
  endtask

  task automatic clear();
    idle(); m_reset = 1; step(); m_reset = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    step();
    chk("reset_src_start", 64'(src_start), 64'd1);
    chk("reset_src_empty", 64'(m_src_empty), 64'd1);
    chk("reset_dst_stop", 64'(dst_stop), 64'd1);
    chk("reset_dst_valid", 64'(dst_valid), 64'd0);

    // Packing
    src_xfer = 1; src_dat_o = 32'h11223344; step();
    src_dat_o = 32'h55667788; src_last = 1; step();
    idle();
    chk("pack_data", m_src, 64'h8877665544332211);
    chk("pack_last", 64'(m_src_last), 64'd1);
    chk("pack_level", 64'(src_level), 64'd1);
    m_src_getn = 0; step(); idle();
    chk("pack_popped", 64'(m_src_empty), 64'd1);

    // Odd last word
    src_xfer = 1; src_last = 1; src_dat_o = 32'hAABBCCDD; step(); idle();
    chk("odd_data", m_src, 64'h00000000DDCCBBAA);
    chk("odd_last", 64'(m_src_last), 64'd1);
    m_src_getn = 0; step(); idle();

    // Unpacking: halves pre-swapped so the DMA side sees the unswapped words
    m_dst_putn = 0; m_dst = {bs(32'h01020304), bs(32'h05060708)}; m_dst_last = 1; step();
    idle();
    chk("unpack_lo", 64'(dst_dat_i), 64'h05060708);
    chk("unpack_valid", 64'(dst_valid), 64'd1);
    dst_xfer = 1; step();
    chk("unpack_hi", 64'(dst_dat_i), 64'h01020304);
    chk("unpack_end", 64'(dst_end), 64'd1);
    step();
    chk("unpack_empty", 64'(dst_valid), 64'd0);
    chk("unpack_ocnt", 64'(ocnt), 64'd0);
    idle();

    // Destination fill and overflow
    clear();
    for (int i = 0; i < 17; i++) begin
      m_dst_putn = 0; m_dst = {32'(i), 32'(i + 100)}; m_dst_last = 0; step();
      if (i == 6)  chk("fill_start_below", 64'(dst_start), 64'd0);
      if (i == 7)  chk("fill_start_at", 64'(dst_start), 64'd1);
      if (i == 14) chk("fill_not_full", 64'(m_dst_full), 64'd0);
      if (i == 15) chk("fill_full", 64'(m_dst_full), 64'd1);
    end
    idle();
    chk("fill_ovf", 64'(dst_ovf), 64'd1);
    chk("fill_ocnt", 64'(ocnt), 64'd17);
    chk("fill_level", 64'(dst_level), 64'd16);

    // Drain
    clear();
    for (int i = 0; i < 3; i++) begin
      m_dst_putn = 0; m_dst = {32'(i), 32'(i)}; step();
    end
    idle();
    chk("drain_idle", 64'(dst_start), 64'd0);
    m_endn = 0; #1;
    chk("drain_start", 64'(dst_start), 64'd1);
    step();

    // Clear mid-job with a half-packed word; reset wins over the same-cycle transfer
    clear();
    src_xfer = 1; src_dat_o = 32'hDEADBEEF; step();
    m_reset = 1; src_dat_o = 32'hCAFEF00D; step();
    idle();
    chk("clr_level", 64'(src_level), 64'd0);
    src_xfer = 1; src_dat_o = 32'h01234567; step();
    src_dat_o = 32'h89ABCDEF; step();
    idle();
    chk("clr_data", m_src, 64'hEFCDAB8967452301);
    chk("clr_last", 64'(m_src_last), 64'd0);
    chk("clr_level1", 64'(src_level), 64'd1);

    // Randomized traffic in phases of differing pop/consume pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 800; c++) begin
        m_reset    = ($urandom_range(0, 299) == 0);
        src_xfer   = ($urandom_range(0, 99) < 60);
        src_last   = ($urandom_range(0, 3) == 0);
        src_dat_o  = $urandom;
        m_src_getn = !($urandom_range(0, 99) < (ph * 25 + 10));
        m_dst_putn = !($urandom_range(0, 99) < 50);
        m_dst      = {$urandom, $urandom};
        m_dst_last = ($urandom_range(0, 4) == 0);
        dst_xfer   = ($urandom_range(0, 99) < (100 - ph * 25));
        m_endn     = ($urandom_range(0, 9) != 0);
        step();
      end
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
